// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared FSM state type and default sizing for the PE row
package pe_pkg;

  localparam int DEF_DATA_W = 19;
  localparam int DEF_COLS   = 6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } pe_state_t;

endpackage

// File: rtl/pe_row_db_if.sv
// rtl/pe_row_db_if.sv - control, activation and weight/sum bus of the PE row
interface pe_row_db_if
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COLS   = DEF_COLS,
  parameter int SUM_W  = 2 * DATA_W
);

  logic                    w_en;
  logic                    w_swap;
  logic                    w_compute;
  logic                    signed_en;
  logic                    in_valid;
  logic [DATA_W-1:0]       active_left;
  logic [DATA_W*COLS-1:0]  in_weight_above;
  logic [SUM_W*COLS-1:0]   in_sum;
  logic [DATA_W-1:0]       active_right;
  logic                    out_valid;
  logic [DATA_W*COLS-1:0]  out_weight_below;
  logic [SUM_W*COLS-1:0]   out_sum;
  logic [COLS-1:0]         out_sum_valid;
  logic                    busy;
  logic                    swap_pending;

  modport slave (
    input  w_en, w_swap, w_compute, signed_en, in_valid, active_left,
           in_weight_above, in_sum,
    output active_right, out_valid, out_weight_below, out_sum,
           out_sum_valid, busy, swap_pending
  );

  modport master (
    output w_en, w_swap, w_compute, signed_en, in_valid, active_left,
           in_weight_above, in_sum,
    input  active_right, out_valid, out_weight_below, out_sum,
           out_sum_valid, busy, swap_pending
  );

endinterface

// File: rtl/pe_cell.sv
// rtl/pe_cell.sv - one PE column: shadow/active weight pair, MAC and activation stage
module pe_cell
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SUM_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              swap_apply,
  input  logic              adv,
  input  logic              signed_en,
  input  logic [DATA_W-1:0] w_in,
  input  logic              a_valid_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [SUM_W-1:0]  sum_in,
  output logic [DATA_W-1:0] shadow_w,
  output logic              a_valid_out,
  output logic [DATA_W-1:0] a_out,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_valid
);

  logic [DATA_W-1:0]         active_w;
  logic [2*DATA_W-1:0]       a_ext;
  logic [2*DATA_W-1:0]       w_ext;
  logic [2*DATA_W-1:0]       prod;
  logic                      prod_ext;
  logic [SUM_W+2*DATA_W-1:0] prod_wide;
  logic [SUM_W-1:0]          prod_fit;

  // Extending both operands to full product width lets one multiplier
  // serve both modes: the low 2*DATA_W bits are the exact product either way.
  assign a_ext     = {{DATA_W{signed_en & a_in[DATA_W-1]}}, a_in};
  assign w_ext     = {{DATA_W{signed_en & active_w[DATA_W-1]}}, active_w};
  assign prod      = a_ext * w_ext;
  assign prod_ext  = signed_en & prod[2*DATA_W-1];
  assign prod_wide = {{SUM_W{prod_ext}}, prod};
  assign prod_fit  = prod_wide[SUM_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_w    <= '0;
      active_w    <= '0;
      a_out       <= '0;
      a_valid_out <= 1'b0;
      sum_out     <= '0;
      sum_valid   <= 1'b0;
    end else begin
      if (w_en) shadow_w <= w_in;
      if (swap_apply) active_w <= shadow_w;
      if (adv) begin
        a_out       <= a_in;
        a_valid_out <= a_valid_in;
        sum_valid   <= a_valid_in;
        if (a_valid_in) sum_out <= sum_in + prod_fit;
      end else begin
        sum_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pe_row_db.sv
// rtl/pe_row_db.sv - systolic PE row with double-buffered weights and drain FSM
module pe_row_db
  import pe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COLS   = DEF_COLS,
  parameter int SUM_W  = 2 * DATA_W
) (
  input  logic            clk,
  input  logic            rst,
  pe_row_db_if.slave      bus
);

  pe_state_t              state_q;
  pe_state_t              state_d;
  logic                   adv;
  logic                   in_valid_eff;
  logic                   any_valid;
  logic                   drain_done;
  logic                   swap_apply;
  logic                   swap_pending_q;
  logic [COLS:0]          v_chain;
  logic [DATA_W-1:0]      a_chain [COLS+1];
  logic [DATA_W*COLS-1:0] shadow_flat;
  logic [SUM_W*COLS-1:0]  sum_flat;
  logic [COLS-1:0]        sum_valid_flat;

  assign v_chain[0] = in_valid_eff;
  assign a_chain[0] = bus.active_left;
  assign any_valid  = |v_chain[COLS:1];

  // A swap may only land when no activation is in flight or entering,
  // so every vector sees one consistent set of weights across the row.
  assign swap_apply = (bus.w_swap | swap_pending_q) & ~any_valid & ~in_valid_eff;

  always_comb begin
    state_d      = state_q;
    adv          = bus.w_compute | (state_q == ST_DRAIN);
    in_valid_eff = bus.in_valid & bus.w_compute;
    drain_done   = 1'b1;
    for (int c = 0; c < COLS - 1; c++) begin
      if (v_chain[c+1]) drain_done = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (bus.w_compute)   state_d = ST_COMPUTE;
        else if (bus.w_en)   state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (bus.w_compute)   state_d = ST_COMPUTE;
        else if (!bus.w_en)  state_d = ST_IDLE;
      end
      ST_COMPUTE: begin
        if (!bus.w_compute)  state_d = any_valid ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (bus.w_compute)   state_d = ST_COMPUTE;
        else if (drain_done) state_d = ST_IDLE;
      end
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      swap_pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (swap_apply)      swap_pending_q <= 1'b0;
      else if (bus.w_swap) swap_pending_q <= 1'b1;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    pe_cell #(
      .DATA_W (DATA_W),
      .SUM_W  (SUM_W)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .w_en        (bus.w_en),
      .swap_apply  (swap_apply),
      .adv         (adv),
      .signed_en   (bus.signed_en),
      .w_in        (bus.in_weight_above[c*DATA_W +: DATA_W]),
      .a_valid_in  (v_chain[c]),
      .a_in        (a_chain[c]),
      .sum_in      (bus.in_sum[c*SUM_W +: SUM_W]),
      .shadow_w    (shadow_flat[c*DATA_W +: DATA_W]),
      .a_valid_out (v_chain[c+1]),
      .a_out       (a_chain[c+1]),
      .sum_out     (sum_flat[c*SUM_W +: SUM_W]),
      .sum_valid   (sum_valid_flat[c])
    );
  end

  assign bus.active_right     = a_chain[COLS];
  assign bus.out_valid        = v_chain[COLS];
  assign bus.out_weight_below = shadow_flat;
  assign bus.out_sum          = sum_flat;
  assign bus.out_sum_valid    = sum_valid_flat;
  assign bus.busy             = (state_q != ST_IDLE);
  assign bus.swap_pending     = swap_pending_q;

endmodule

// File: tb/tb_pe_row_db.sv
// tb/tb_pe_row_db.sv - self-checking bench for pe_row_db against a behavioural row model
module tb_pe_row_db;

  localparam int DATA_W = 19;
  localparam int COLS   = 6;
  localparam int SUM_W  = 38;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  bit   chk_en   = 1'b0;

  pe_row_db_if #(.DATA_W(DATA_W), .COLS(COLS), .SUM_W(SUM_W)) bus ();

  pe_row_db #(.DATA_W(DATA_W), .COLS(COLS), .SUM_W(SUM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Row model: state names 0 idle, 1 load, 2 compute, 3 drain.
  logic [DATA_W-1:0] m_shadow [COLS];
  logic [DATA_W-1:0] m_active [COLS];
  logic [DATA_W-1:0] m_act    [COLS];
  logic [SUM_W-1:0]  m_sum    [COLS];
  bit                m_v      [COLS];
  bit                m_sv     [COLS];
  bit                m_pend;
  int                m_st;
  bit                adv, iv, anyv, emp, swp, nv;
  logic [DATA_W-1:0] na;
  logic [DATA_W*COLS-1:0] e_wb;
  logic [SUM_W*COLS-1:0]  e_sum;
  logic [COLS-1:0]        e_sv;

  function automatic logic [SUM_W-1:0] mac(input logic [SUM_W-1:0] s, input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] w, input bit sgn);
    longint ia, iw, tot;
    ia  = sgn ? longint'($signed(a)) : longint'(a);
    iw  = sgn ? longint'($signed(w)) : longint'(w);
    tot = longint'(s) + ia * iw;
    return SUM_W'(tot);
  endfunction

  // Outputs are compared at the falling edge, then the model absorbs the
  // inputs that the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int c = 0; c < COLS; c++) begin
          e_wb[c*DATA_W +: DATA_W] = m_shadow[c];
          e_sum[c*SUM_W +: SUM_W]  = m_sum[c];
          e_sv[c]                  = m_sv[c];
        end
        chk("out_weight_below", 256'(bus.out_weight_below), 256'(e_wb));
        chk("out_sum", 256'(bus.out_sum), 256'(e_sum));
        chk("out_sum_valid", 256'(bus.out_sum_valid), 256'(e_sv));
        chk("out_valid", 256'(bus.out_valid), 256'(m_v[COLS-1]));
        chk("active_right", 256'(bus.active_right), 256'(m_act[COLS-1]));
        chk("busy", 256'(bus.busy), 256'(m_st != 0));
        chk("swap_pending", 256'(bus.swap_pending), 256'(m_pend));
      end
      if (rst) begin
        for (int c = 0; c < COLS; c++) begin
          m_shadow[c] = '0; m_active[c] = '0; m_act[c] = '0;
          m_sum[c] = '0; m_v[c] = 1'b0; m_sv[c] = 1'b0;
        end
        m_pend = 1'b0;
        m_st   = 0;
        chk_en = 1'b1;
      end else begin
        adv  = bus.w_compute || (m_st == 3);
        iv   = bus.in_valid && bus.w_compute;
        anyv = 1'b0;
        for (int c = 0; c < COLS; c++) anyv |= m_v[c];
        swp = (bus.w_swap || m_pend) && !anyv && !iv;
        for (int c = COLS - 1; c >= 0; c--) begin
          if (c == 0) begin nv = iv; na = bus.active_left; end
          else begin nv = m_v[c-1]; na = m_act[c-1]; end
          if (adv) begin
            if (nv) m_sum[c] = mac(bus.in_sum[c*SUM_W +: SUM_W], na, m_active[c], bus.signed_en);
            m_v[c] = nv; m_act[c] = na; m_sv[c] = nv;
          end else begin
            m_sv[c] = 1'b0;
          end
        end
        for (int c = 0; c < COLS; c++) begin
          if (swp) m_active[c] = m_shadow[c];
          if (bus.w_en) m_shadow[c] = bus.in_weight_above[c*DATA_W +: DATA_W];
        end
        m_pend = swp ? 1'b0 : (bus.w_swap || m_pend);
        emp = 1'b1;
        for (int c = 0; c < COLS; c++) if (m_v[c]) emp = 1'b0;
        case (m_st)
          0: if (bus.w_compute) m_st = 2; else if (bus.w_en) m_st = 1;
          1: if (bus.w_compute) m_st = 2; else if (!bus.w_en) m_st = 0;
          2: if (!bus.w_compute) m_st = anyv ? 3 : 0;
          default: if (bus.w_compute) m_st = 2; else if (emp) m_st = 0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_in();
    bus.w_en = 1'b0; bus.w_swap = 1'b0; bus.w_compute = 1'b0; bus.signed_en = 1'b0;
    bus.in_valid = 1'b0; bus.active_left = '0; bus.in_weight_above = '0; bus.in_sum = '0;
  endtask

  function automatic logic [DATA_W*COLS-1:0] wvec(input logic [DATA_W-1:0] c0, input logic [DATA_W-1:0] cl);
    logic [DATA_W*COLS-1:0] r;
    r = '0;
    r[0 +: DATA_W] = c0;
    r[(COLS-1)*DATA_W +: DATA_W] = cl;
    return r;
  endfunction

  function automatic logic [SUM_W*COLS-1:0] sum0(input logic [SUM_W-1:0] v);
    return {{(SUM_W*(COLS-1)){1'b0}}, v};
  endfunction

  task automatic vec(input logic [DATA_W-1:0] a, input logic [SUM_W-1:0] s, input bit sgn);
    bus.w_compute = 1'b1; bus.in_valid = 1'b1; bus.active_left = a;
    bus.in_sum = sum0(s); bus.signed_en = sgn;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic flush();
    repeat (COLS) tick();
    bus.w_compute = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    clr_in();
    rst = 1'b1;
    bus.w_en = 1'b1; bus.w_swap = 1'b1; bus.w_compute = 1'b1; bus.in_valid = 1'b1;
    bus.in_weight_above = '1; bus.active_left = '1; bus.in_sum = '1;
    tick(); tick();
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_sum", 256'(bus.out_sum), 256'(0));
    chk("rst_weights", 256'(bus.out_weight_below), 256'(0));
    rst = 1'b0;
    clr_in();

    // load, swap, one vector through the row
    bus.w_en = 1'b1; bus.in_weight_above = wvec(19'd5, 19'd7);
    tick();
    chk("load_busy", 256'(bus.busy), 256'(1));
    chk("load_pass_down", 256'(bus.out_weight_below), 256'(wvec(19'd5, 19'd7)));
    bus.w_en = 1'b0; bus.w_swap = 1'b1;
    tick();
    chk("swap_now", 256'(bus.swap_pending), 256'(0));
    bus.w_swap = 1'b0;
    vec(19'd3, '0, 1'b0);
    chk("load_sum0", 256'(bus.out_sum[SUM_W-1:0]), 256'(15));
    repeat (4) tick();
    chk("load_no_out_valid_yet", 256'(bus.out_valid), 256'(0));
    tick();
    chk("load_sum_last", 256'(bus.out_sum[(COLS-1)*SUM_W +: SUM_W]), 256'(21));
    chk("load_out_valid", 256'(bus.out_valid), 256'(1));
    chk("load_active_right", 256'(bus.active_right), 256'(3));
    tick();
    bus.w_compute = 1'b0;
    tick();
    chk("load_idle", 256'(bus.busy), 256'(0));

    // load coinciding with swap: active takes old shadow
    bus.w_en = 1'b1; bus.w_swap = 1'b1; bus.in_weight_above = wvec(19'h7FFFE, 19'd0);
    tick();
    bus.w_en = 1'b0; bus.w_swap = 1'b0;
    vec(19'd3, 38'd10, 1'b0);
    chk("swap_load_old", 256'(bus.out_sum[SUM_W-1:0]), 256'(25));
    flush();
    bus.w_swap = 1'b1;
    tick();
    bus.w_swap = 1'b0;
    vec(19'd3, 38'd10, 1'b1);
    chk("signed_sum", 256'(bus.out_sum[SUM_W-1:0]), 256'(4));
    flush();
    vec(19'd3, 38'd10, 1'b0);
    chk("unsigned_sum", 256'(bus.out_sum[SUM_W-1:0]), 256'(1572868));
    flush();

    // modulo wrap
    bus.w_en = 1'b1; bus.in_weight_above = wvec(19'd1, 19'd0);
    tick();
    bus.w_en = 1'b0; bus.w_swap = 1'b1;
    tick();
    bus.w_swap = 1'b0;
    vec(19'd1, '1, 1'b0);
    chk("wrap_sum", 256'(bus.out_sum[SUM_W-1:0]), 256'(0));
    chk("wrap_valid", 256'(bus.out_sum_valid[0]), 256'(1));
    flush();

    // deferred swap
    bus.w_en = 1'b1; bus.in_weight_above = wvec(19'd4, 19'd0);
    tick();
    bus.w_en = 1'b0;
    vec(19'd2, '0, 1'b0);
    chk("defer_old_a", 256'(bus.out_sum[SUM_W-1:0]), 256'(2));
    bus.in_valid = 1'b1; bus.w_swap = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.w_swap = 1'b0;
    chk("defer_pending", 256'(bus.swap_pending), 256'(1));
    chk("defer_old_b", 256'(bus.out_sum[SUM_W-1:0]), 256'(2));
    repeat (COLS) tick();
    chk("defer_still_pending", 256'(bus.swap_pending), 256'(1));
    tick();
    chk("defer_applied", 256'(bus.swap_pending), 256'(0));
    vec(19'd2, '0, 1'b0);
    chk("defer_new", 256'(bus.out_sum[SUM_W-1:0]), 256'(8));
    flush();

    // drain with three stages valid
    bus.w_compute = 1'b1; bus.in_valid = 1'b1; bus.in_sum = '0;
    for (int i = 1; i <= 3; i++) begin
      bus.active_left = DATA_W'(i);
      tick();
    end
    bus.w_compute = 1'b0; bus.in_valid = 1'b0;
    tick();
    chk("drain_busy", 256'(bus.busy), 256'(1));
    chk("drain_freeze_sv", 256'(bus.out_sum_valid), 256'(0));
    n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    chk("drain_cycles", 256'(n), 256'(6));

    // reset while computing
    bus.w_compute = 1'b1; bus.in_valid = 1'b1; bus.active_left = 19'd5;
    bus.w_en = 1'b1; bus.in_weight_above = wvec(19'd9, 19'd9); bus.w_swap = 1'b1;
    tick();
    bus.w_swap = 1'b0;
    tick(); tick();
    rst = 1'b1; bus.w_swap = 1'b1;
    tick();
    chk("rst_mid_busy", 256'(bus.busy), 256'(0));
    chk("rst_mid_sum", 256'(bus.out_sum), 256'(0));
    chk("rst_mid_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_mid_pending", 256'(bus.swap_pending), 256'(0));
    rst = 1'b0;
    clr_in();
    vec(19'd5, 38'd7, 1'b0);
    chk("post_rst_zero_w", 256'(bus.out_sum[SUM_W-1:0]), 256'(7));
    flush();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_row_db.md
PE_ROW_DB -- requirements
Module: pe_row_db

Interface
REQ-001 SHALL have parameter DATA_W, default 19, activation/weight width in bits.
REQ-002 SHALL have parameter COLS, default 6, PE columns in the row (legal range 1..32).
REQ-003 SHALL have parameter SUM_W, default 2*DATA_W, partial-sum width per column.
REQ-004 SHALL have one clock and one synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports:
- w_en  input  1  shadow-weight load strobe.
- w_swap  input  1  request to copy shadow weights to active weights.
- w_compute  input  1  compute enable.
- signed_en  input  1  1 = two's-complement multiply, 0 = unsigned.
- in_valid  input  1  active_left qualifier.
- active_left  input  DATA_W  activation from left.
- in_weight_above  input  DATA_W*COLS  weights from above, column c at bits [c*DATA_W +: DATA_W].
- in_sum  input  SUM_W*COLS  partial sums from above.
- active_right  output  DATA_W  activation leaving the last column.
- out_valid  output  1  active_right qualifier.
- out_weight_below  output  DATA_W*COLS  registered shadow weights.
- out_sum  output  SUM_W*COLS  registered partial sums.
- out_sum_valid  output  COLS  per-column sum qualifier.
- busy  output  1  state is not IDLE.
- swap_pending  output  1  swap requested but not yet applied.

Function
REQ-006 SHALL hold per column a shadow weight register and an active weight register.
REQ-007 SHALL, on any edge with w_en=1, load shadow[c] from in_weight_above[c]; out_weight_below SHALL equal shadow (1-cycle pass-down latency).
REQ-008 SHALL, while w_compute=1, advance an activation/valid pipeline one column per cycle: stage 0 captures {in_valid, active_left}; stage c captures stage c-1.
REQ-009 SHALL drive active_right/out_valid from stage COLS-1, giving COLS cycles of latency from active_left.
REQ-010 SHALL, when stage c is valid, register out_sum[c] = in_sum[c] + act_c*active_w[c] and set out_sum_valid[c]=1; otherwise out_sum[c] holds and out_sum_valid[c]=0.
REQ-011 SHALL form the product as a 2*DATA_W-bit signed or unsigned value per signed_en; the product SHALL be sign- or zero-extended, or truncated, to SUM_W; the sum SHALL wrap modulo 2^SUM_W.
REQ-012 SHALL freeze the pipeline (hold all stages and outputs, clear out_sum_valid) while w_compute=0 in COMPUTE.
REQ-013 SHALL implement FSM IDLE, LOAD, COMPUTE, DRAIN:
- IDLE->LOAD on w_en.
- IDLE/LOAD->COMPUTE on w_compute; w_compute has priority over w_en for state, and w_en still loads shadow.
- LOAD->IDLE when w_en=0 and w_compute=0.
- COMPUTE->DRAIN when w_compute falls while any stage is valid; otherwise COMPUTE->IDLE.
- DRAIN shifts with in_valid forced to 0 and returns to IDLE when all stages are invalid.
- DRAIN->COMPUTE if w_compute reasserts.
REQ-014 SHALL apply w_swap (active=shadow) on the same edge only when no pipeline stage is valid and in_valid is not being captured; otherwise it SHALL set swap_pending, and apply the swap and clear swap_pending on the first edge meeting that condition.
REQ-015 SHALL, when w_en and an applied swap coincide, copy the old shadow value to active and load the new value into shadow.
REQ-016 SHALL drive busy=1 in LOAD, COMPUTE and DRAIN.

Reset
REQ-017 SHALL, on rst=1 at a clock edge, clear all shadow and active weights, pipeline stages, out_sum, out_sum_valid, active_right, out_valid and swap_pending to 0, and set state to IDLE, regardless of the current state or in-flight data.
REQ-018 SHALL ignore all other inputs during the reset cycle.

Structure
REQ-019 SHALL place the FSM state enum and default parameter constants in shared package pe_pkg.
REQ-020 SHALL build each column from one sub-module, pe_cell (weight pair, MAC, stage register), instantiated COLS times by generate.

Verification
REQ-021 SHALL cover load: w_en with col0=5 and col5=7, then w_swap, then w_compute, in_valid with active_left=3 and in_sum=0 -> out_sum[0]=15 one cycle later, out_sum[5]=21 at cycle 6, out_valid at cycle 6.
REQ-022 SHALL cover signed mode: signed_en=1, weight=-2, act=3, in_sum=10 -> out_sum=4; signed_en=0 with the same bits -> unsigned result.
REQ-023 SHALL cover deferred swap: w_swap mid-vector -> swap_pending=1 until the pipeline empties, then the new weights are used for the next vector only.
REQ-024 SHALL cover drain: w_compute drops with 3 stages valid -> DRAIN for 3+ cycles, busy=1, then IDLE and busy=0.
REQ-025 SHALL cover wrap: in_sum=2^SUM_W-1 and product 1 -> out_sum=0.
REQ-026 SHALL cover reset in COMPUTE with a valid pipe -> all outputs 0 and state IDLE on the next edge.
